// File: rtl/prog_loader_pkg.sv
// Shared definitions for the multi-bank program loader: FSM encoding, error
// codes and the default end-of-image marker.
package prog_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_BANK = 2'd1,
    ERR_OVF  = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  // Wide enough for the largest DATA_WIDTH; only the low DATA_WIDTH bits are compared.
  localparam logic [63:0] END_MARKER_DEFAULT = 64'h0000_0000_0000_0FFF;

endpackage

// File: rtl/prog_word_packer.sv
// Packs a byte stream little-endian into DATA_WIDTH words. word_vld_o flags the
// byte that completes a word; the finished word is on word_o from the next cycle.
module prog_word_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  byte_vld_i,
  input  logic [7:0]            byte_i,
  output logic                  word_vld_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH+7:0] shifted;
  logic                  last_byte;

  assign last_byte = (cnt_q == CNT_W'(NUM_BYTES - 1));
  // New bytes enter at the top, so the first byte ends up in bits [7:0].
  assign shifted   = {byte_i, word_q} >> 8;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q;
    word_d     = word_q;
    word_vld_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (byte_vld_i) begin
      word_d = shifted[DATA_WIDTH-1:0];
      if (last_byte) begin
        cnt_d      = '0;
        word_vld_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/prog_loader.sv
// Multi-bank program loader: header byte selects the target SRAM, payload bytes
// are packed into words and written until the end marker, with error reporting.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 12,
  parameter int          DEPTH          = 2048,
  parameter int          NUM_BANKS      = 2,
  parameter logic [63:0] END_MARKER     = END_MARKER_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  prog_i,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic [NUM_BANKS-1:0]  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  prog_rst_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            err_o,
  output logic [ADDR_WIDTH:0]   words_o
);

  localparam int                BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [31:0]       TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [NUM_BANKS-1:0]  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  prst_n_q, prst_n_d;
  logic                  done_q, done_d;
  err_e                  err_q, err_d;
  logic [31:0]           idle_q;

  logic                  in_payload, counting, tmo_hit, word_vld, is_marker;
  logic [DATA_WIDTH-1:0] word;

  assign in_payload = (state_q == ST_DATA) || (state_q == ST_WRITE);
  assign counting   = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && counting && !rx_dv_i && (idle_q == TMO_LAST);
  assign is_marker  = (word == END_MARKER[DATA_WIDTH-1:0]);

  prog_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (!in_payload),
    .byte_vld_i (rx_dv_i && in_payload),
    .byte_i     (rx_byte_i),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    cnt_d    = cnt_q;
    we_d     = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prst_n_d = prst_n_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: if (prog_i) begin
        state_d  = ST_HDR;
        prst_n_d = 1'b0;
        err_d    = ERR_NONE;
        cnt_d    = '0;
      end
      ST_HDR, ST_DATA: begin
        if (!prog_i) begin
          state_d  = ST_IDLE;
          prst_n_d = 1'b1;
        end else if (state_q == ST_HDR && rx_dv_i) begin
          if (rx_byte_i < 8'(NUM_BANKS)) begin
            bank_d  = rx_byte_i[BANK_W-1:0];
            state_d = ST_DATA;
          end else begin
            err_d   = ERR_BANK;
            state_d = ST_ERR;
          end
        end else if (word_vld) begin
          state_d = ST_WRITE;
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = ST_ERR;
        end
      end
      ST_WRITE: begin
        // An abort lets a pending write land but never reports done or an error.
        if (is_marker) begin
          state_d  = prog_i ? ST_DONE : ST_IDLE;
          done_d   = prog_i;
          prst_n_d = 1'b1;
        end else if (cnt_q == DEPTH_C) begin
          state_d  = prog_i ? ST_ERR : ST_IDLE;
          err_d    = prog_i ? ERR_OVF : err_q;
          prst_n_d = !prog_i;
        end else begin
          we_d[bank_q] = 1'b1;
          addr_d       = cnt_q[ADDR_WIDTH-1:0];
          wdata_d      = word;
          cnt_d        = cnt_q + 1'b1;
          state_d      = prog_i ? ST_DATA : ST_IDLE;
          prst_n_d     = !prog_i;
        end
      end
      ST_DONE: if (!prog_i) state_d = ST_IDLE;
      ST_ERR: if (!prog_i) begin
        state_d  = ST_IDLE;
        prst_n_d = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        prst_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      bank_q   <= '0;
      cnt_q    <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prst_n_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prst_n_q <= prst_n_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Idle gap counter between received bytes while a session is waiting for input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     idle_q <= '0;
    else if (!counting || rx_dv_i) idle_q <= '0;
    else                           idle_q <= idle_q + 32'd1;
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign prog_rst_no = prst_n_q;
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign words_o     = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed session table, hand-written
// corner sequences and randomized sessions against a session-level model.
module tb_prog_loader;

  localparam int          DW     = 32;
  localparam int          AW     = 2;
  localparam int          DEPTH  = 4;
  localparam int          NB     = 2;
  localparam logic [31:0] MARKER = 32'h0000_0FFF;
  localparam int          TMO    = 100;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          prog_i = 1'b0;
  logic          rx_dv_i = 1'b0;
  logic [7:0]    rx_byte_i = 8'h00;
  logic [NB-1:0] we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          prog_rst_no, busy_o, done_o;
  logic [1:0]    err_o;
  logic [AW:0]   words_o;

  prog_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_BANKS(NB),
    .END_MARKER(64'(MARKER)), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .prog_i(prog_i), .rx_dv_i(rx_dv_i),
    .rx_byte_i(rx_byte_i), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .prog_rst_no(prog_rst_no), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]         hdr;
    int                 n;
    logic [7:0][DW-1:0] w;
    logic [1:0]         err;
    int                 writes;
    int                 done;
  } vec_t;

  wr_t           wq[$];
  int            done_cnt = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] wbuf [8];

  // Passive observer of the SRAM write port and the done pulse.
  always @(negedge clk) begin
    if (!rst_i && we_o != '0) wq.push_back('{we: we_o, addr: addr_o, data: wdata_o});
    if (!rst_i && done_o) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_byte_i = b;
    rx_dv_i   = 1'b1;
    tick();
    rx_dv_i   = 1'b0;
    rx_byte_i = 8'($urandom);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap_max);
    for (int k = 0; k < DW / 8; k++) send_byte(w[8*k +: 8], int'($urandom_range(0, gap_max)));
  endtask

  task automatic start_session(input logic [7:0] hdr);
    wq.delete();
    done_cnt = 0;
    prog_i = 1'b1;
    tick();
    send_byte(hdr, 1);
  endtask

  // Session-level reference: first marker ends it, the write past DEPTH overflows.
  function automatic void model(input logic [7:0] hdr, input int n,
                                output logic [1:0] err, output int wr, output int dn);
    err = 2'd0; wr = 0; dn = 0;
    if (int'(hdr) >= NB) begin err = 2'd1; return; end
    for (int i = 0; i < n; i++) begin
      if (wbuf[i] == MARKER) begin dn = 1; return; end
      if (wr == DEPTH) begin err = 2'd2; return; end
      wr++;
    end
  endfunction

  task automatic run_session(input string tag, input logic [7:0] hdr, input int n, input int gap_max,
                             input logic [1:0] exp_err, input int exp_wr, input int exp_done);
    start_session(hdr);
    for (int i = 0; i < n; i++) send_word(wbuf[i], gap_max);
    repeat (4) tick();
    check({tag, " err_o"}, 64'(err_o), 64'(exp_err));
    check({tag, " words_o"}, 64'(words_o), 64'(exp_wr));
    check({tag, " done pulses"}, 64'(done_cnt), 64'(exp_done));
    check({tag, " write count"}, 64'(wq.size()), 64'(exp_wr));
    for (int i = 0; i < wq.size() && i < exp_wr; i++) begin
      check({tag, " write we"}, 64'(wq[i].we), 64'(1 << hdr));
      check({tag, " write addr"}, 64'(wq[i].addr), 64'(i));
      check({tag, " write data"}, 64'(wq[i].data), 64'(wbuf[i]));
    end
    check({tag, " prog_rst_no"}, 64'(prog_rst_no), 64'(exp_done != 0));
    check({tag, " busy_o"}, 64'(busy_o), 64'(exp_done == 0));
    prog_i = 1'b0;
    repeat (2) tick();
    check({tag, " rst released"}, 64'(prog_rst_no), 64'd1);
    check({tag, " idle busy"}, 64'(busy_o), 64'd0);
    check({tag, " err held"}, 64'(err_o), 64'(exp_err));
  endtask

  function automatic vec_t mk(input logic [7:0] h, input int n,
                              input logic [DW-1:0] a, b, c, d, e, f,
                              input logic [1:0] err, input int wr, input int dn);
    vec_t v;
    v.hdr = h; v.n = n; v.w = '0;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e; v.w[5] = f;
    v.err = err; v.writes = wr; v.done = dn;
    return v;
  endfunction

  vec_t vecs [9];

  initial begin
    vecs[0] = mk(8'h00, 3, 32'h0000_0013, 32'h0010_0093, MARKER, 0, 0, 0, 2'd0, 2, 1);
    vecs[1] = mk(8'h01, 2, 32'hDEAD_BEEF, MARKER, 0, 0, 0, 0, 2'd0, 1, 1);
    vecs[2] = mk(8'h05, 2, 32'h1111_1111, MARKER, 0, 0, 0, 0, 2'd1, 0, 0);
    vecs[3] = mk(8'h00, 5, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 0, 2'd2, 4, 0);
    vecs[4] = mk(8'h02, 1, MARKER, 0, 0, 0, 0, 0, 2'd1, 0, 0);
    vecs[5] = mk(8'h01, 1, MARKER, 0, 0, 0, 0, 0, 2'd0, 0, 1);
    vecs[6] = mk(8'h00, 2, 32'h0000_0FFE, MARKER, 0, 0, 0, 0, 2'd0, 1, 1);
    vecs[7] = mk(8'h01, 5, 32'hA, 32'hB, 32'hC, 32'hD, MARKER, 0, 2'd0, 4, 1);
    vecs[8] = mk(8'h00, 2, 32'hCAFE_0001, 32'hCAFE_0002, 0, 0, 0, 0, 2'd0, 2, 0);

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("reset we_o", 64'(we_o), 64'd0);
    check("reset addr_o", 64'(addr_o), 64'd0);
    check("reset wdata_o", 64'(wdata_o), 64'd0);
    check("reset prog_rst_no", 64'(prog_rst_no), 64'd1);
    check("reset busy/done/err", 64'({busy_o, done_o, err_o}), 64'd0);
    check("reset words_o", 64'(words_o), 64'd0);
    rst_i = 1'b0;
    tick();

    foreach (vecs[v]) begin
      for (int i = 0; i < 8; i++) wbuf[i] = vecs[v].w[i];
      run_session($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].n, 2,
                  vecs[v].err, vecs[v].writes, vecs[v].done);
    end

    // prog_i kept high after done: no restart, stray bytes ignored.
    start_session(8'h01);
    send_word(MARKER, 0);
    repeat (20) tick();
    send_word(32'h1234_5678, 0);
    repeat (5) tick();
    check("hold done pulses", 64'(done_cnt), 64'd1);
    check("hold busy", 64'(busy_o), 64'd0);
    check("hold no writes", 64'(wq.size()), 64'd0);
    prog_i = 1'b0;
    repeat (2) tick();

    // Timeout: header plus two bytes, then silence.
    start_session(8'h00);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (TMO - 1) tick();
    check("tmo not yet", 64'(err_o), 64'd0);
    tick();
    check("tmo err_o", 64'(err_o), 64'd3);
    check("tmo prog_rst_no", 64'(prog_rst_no), 64'd0);
    check("tmo no write", 64'(wq.size()), 64'd0);
    prog_i = 1'b0;
    repeat (2) tick();
    check("tmo err held", 64'(err_o), 64'd3);
    check("tmo rst released", 64'(prog_rst_no), 64'd1);
    prog_i = 1'b1;
    repeat (2) tick();
    check("new session clears err", 64'(err_o), 64'd0);
    prog_i = 1'b0;
    repeat (2) tick();

    // Abort mid-word: earlier write stays, no done, no error.
    start_session(8'h00);
    send_word(32'h5555_AAAA, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    prog_i = 1'b0;
    repeat (3) tick();
    check("abort writes", 64'(wq.size()), 64'd1);
    check("abort words_o", 64'(words_o), 64'd1);
    check("abort err/done", 64'({err_o, 2'(done_cnt)}), 64'd0);
    check("abort prog_rst_no", 64'(prog_rst_no), 64'd1);

    // Asynchronous reset after the second write, then a fresh session.
    start_session(8'h00);
    send_word(32'h0000_00A1, 0);
    send_word(32'h0000_00A2, 0);
    for (int t = 0; t < 50 && wq.size() < 2; t++) tick();
    check("pre-reset writes", 64'(wq.size()), 64'd2);
    #2 rst_i = 1'b1;
    #1;
    check("async rst we/addr", 64'({we_o, addr_o}), 64'd0);
    check("async rst wdata", 64'(wdata_o), 64'd0);
    check("async rst flags", 64'({prog_rst_no, busy_o, done_o, err_o}), 64'b10000);
    check("async rst words", 64'(words_o), 64'd0);
    prog_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    wbuf[0] = 32'h0BAD_F00D;
    wbuf[1] = MARKER;
    run_session("post-reset", 8'h00, 2, 1, 2'd0, 1, 1);

    // Randomized sessions checked against the session model.
    for (int r = 0; r < 12; r++) begin
      logic [7:0] hdr;
      logic [1:0] e;
      int         n, wr, dn;
      hdr = 8'($urandom_range(0, 4) == 0 ? $urandom_range(2, 255) : $urandom_range(0, NB - 1));
      n   = int'($urandom_range(0, 6));
      for (int i = 0; i < 8; i++) wbuf[i] = ($urandom_range(0, 4) == 0) ? MARKER : $urandom;
      model(hdr, n, e, wr, dn);
      run_session($sformatf("rand%0d", r), hdr, n, 3, e, wr, dn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
